udp_msg_parser: RTL and testbench
=================================

// Module: udp_msg_parser
// PURPOSE
//  Consumes the UDP-payload byte stream produced by udp_packet_filter (valid/data, 1 byte/cycle, no backpressure).
//  Splits each payload into length-prefixed market-data messages and decodes Add-Order messages into fixed records.
//  Records are buffered in a small FWFT FIFO and presented on a valid/ready interface to the order-book stage.
// PARAMETERS
//  FIFO_DEPTH  4   record FIFO entries; power of 2, >=2
//  CNT_W       16  width of statistics counters (MSG_STATS_EN only)
// PORTS
//  clk           in   1   single clock; all logic on posedge
//  reset_n       in   1   asynchronous, active-low reset
//  in_valid      in   1   payload byte valid; any low cycle = end of packet
//  in_data       in   8   payload byte, network (big-endian) order
//  msg_valid     out  1   record available at FIFO head
//  msg_ready     in   1   consumer accepts head when msg_valid&&msg_ready
//  msg_side      out  1   1=buy ('B' 0x42), 0=sell ('S' 0x53)
//  msg_order_id  out  32  order id
//  msg_price     out  32  price, unsigned
//  msg_qty       out  16  quantity, unsigned
//  ovf_pulse     out  1   1-cycle pulse: completed record dropped, FIFO full
//  err_pulse     out  1   1-cycle pulse: malformed or truncated message
// BEHAVIOUR
//  Message = LEN(1, total bytes incl. LEN) | TYPE(1) | body(LEN-2). Messages are back-to-back inside a packet.
//  Add-Order: TYPE=0x41, LEN=13; body = SIDE(1) ORDER_ID(4) PRICE(4) QTY(2), MSB first.
//  FSM states: S_LEN, S_TYPE, S_ADD, S_SKIP, S_DRAIN. Reset state S_LEN.
//   S_LEN : in_valid: LEN<2 -> err_pulse, S_DRAIN; else latch LEN -> S_TYPE.
//   S_TYPE: 0x41 & LEN==13 -> S_ADD; 0x41 & LEN!=13 -> err, S_DRAIN; other type: LEN==2 -> S_LEN, else S_SKIP.
//   S_ADD : shift body bytes; SIDE not 0x42/0x53 -> err, S_DRAIN; after QTY LSB -> push record, S_LEN.
//   S_SKIP: discard LEN-2 bytes, then S_LEN.
//   S_DRAIN: discard bytes until end of packet.
//  in_valid==0 in any state -> S_LEN next cycle; if state was S_TYPE/S_ADD/S_SKIP, err_pulse (truncated), partial record discarded.
//  Byte counter: 8-bit, reloaded per message; no wrap within a message since LEN<=255.
//  Latency: QTY LSB sampled at edge k -> FIFO write at edge k+1 -> msg_valid high after edge k+1 when FIFO was empty.
//  FIFO: FWFT; msg_* show head, hold stable while msg_valid && !msg_ready.
//  Push when full with no pop -> record dropped, ovf_pulse; push+pop same cycle when full -> both take effect, no drop.
//  Push+pop when empty: push takes effect; msg_valid high next cycle.
//  Reset (async assert, any time incl. mid-message): FSM S_LEN, FIFO empty; msg_valid, ovf_pulse, err_pulse,
//   msg_side, msg_order_id, msg_price, msg_qty all 0; stats cleared.
// CONFIGURATION
//  MSG_STATS_EN defined: extra outputs stat_msgs, stat_err, stat_ovf [CNT_W-1:0], each saturating at all-ones.
//   stat_msgs counts records pushed; stat_err counts err_pulse; stat_ovf counts ovf_pulse.
//  MSG_STATS_EN undefined: stat_* ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package udp_msg_pkg: msg_rec_t struct {side, order_id, price, qty} (81 bits); parser_state_e enum;
//   constants MSG_TYPE_ADD=8'h41, MSG_LEN_ADD=8'd13, SIDE_BUY=8'h42, SIDE_SELL=8'h53.
//  Sub-module msg_rec_fifo: parameterised FWFT FIFO of msg_rec_t, wr_en/full/rd_en/empty, async active-low reset.
//  Top: FSM, body shift register, push/ovf logic, optional stats.
// TESTING
//  T1 payload {0D,41,42,00,00,00,2A,00,01,86,A0,00,64}, ready=1 -> one record side=1 id=42 price=100000 qty=100,
//     msg_valid 2 edges after last byte sampled.
//  T2 payload {04,58,AA,BB, then T1 message} -> exactly one record, same fields as T1; no err_pulse.
//  T3 T1 payload cut after 7 bytes (in_valid drops) -> no record, one err_pulse; next full T1 packet parses normally.
//  T4 payload {01,..} and {0C,41,..} in separate packets -> err_pulse each, rest of packet ignored,
//     next packet parses normally.
//  T5 ready=0, one packet with 5 Add msgs (ids 1..5), depth 4 -> ids 1-4 held, one ovf_pulse on id 5;
//     ready=1 -> ids 1,2,3,4 in order, one per cycle.
//  T6 reset_n low mid Add body with FIFO holding 2 records -> msg_valid=0 immediately, FIFO empty;
//     after release, T1 packet yields one record.
//  With MSG_STATS_EN: after T1-T5 sequence check stat_msgs, stat_err, stat_ovf match pulse counts.

Source files
------------

// File: rtl/udp_msg_pkg.sv
// Shared types and protocol constants for the UDP market-data message parser.
package udp_msg_pkg;

  localparam logic [7:0] MSG_TYPE_ADD = 8'h41;
  localparam logic [7:0] MSG_LEN_ADD  = 8'd13;
  localparam logic [7:0] SIDE_BUY     = 8'h42;
  localparam logic [7:0] SIDE_SELL    = 8'h53;

  typedef struct packed {
    logic        side;
    logic [31:0] order_id;
    logic [31:0] price;
    logic [15:0] qty;
  } msg_rec_t;

  typedef enum logic [2:0] {
    S_LEN,
    S_TYPE,
    S_ADD,
    S_SKIP,
    S_DRAIN
  } parser_state_e;

endpackage

// File: rtl/msg_rec_fifo.sv
// First-word-fall-through record FIFO; head is presented combinationally, zero when empty.
module msg_rec_fifo
  import udp_msg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_en,
  input  msg_rec_t wr_data,
  output logic     full,
  input  logic     rd_en,
  output msg_rec_t rd_data,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  msg_rec_t      mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          wr_ok, rd_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_ok   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/udp_msg_parser.sv
// Splits UDP payloads into length-prefixed messages and decodes Add-Order records into a FWFT FIFO.
// Define MSG_STATS_EN to add saturating stat_msgs/stat_err/stat_ovf counters.
module udp_msg_parser
  import udp_msg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
`ifdef MSG_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic        msg_side,
  output logic [31:0] msg_order_id,
  output logic [31:0] msg_price,
  output logic [15:0] msg_qty,
  output logic        ovf_pulse,
  output logic        err_pulse
`ifdef MSG_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_msgs,
  output logic [CNT_W-1:0] stat_err,
  output logic [CNT_W-1:0] stat_ovf
`endif
);

  parser_state_e state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [87:0]   body_q, body_d;
  logic          push_q, push_d;
  logic          err_q, err_d;
  logic          ovf_q;

  msg_rec_t      rec, head;
  logic          fifo_full, fifo_empty, fifo_wr, pop;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    body_d  = body_q;
    push_d  = 1'b0;
    err_d   = 1'b0;
    if (!in_valid) begin
      // A gap ends the packet; anything mid-message is truncated.
      state_d = S_LEN;
      err_d   = (state_q inside {S_TYPE, S_ADD, S_SKIP});
    end else begin
      case (state_q)
        S_LEN: begin
          if (in_data < 8'd2) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            len_d   = in_data;
            state_d = S_TYPE;
          end
        end
        S_TYPE: begin
          if (in_data == MSG_TYPE_ADD) begin
            if (len_q == MSG_LEN_ADD) begin
              cnt_d   = len_q - 8'd2;
              state_d = S_ADD;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (len_q == 8'd2) begin
            state_d = S_LEN;
          end else begin
            cnt_d   = len_q - 8'd2;
            state_d = S_SKIP;
          end
        end
        S_ADD: begin
          body_d = {body_q[79:0], in_data};
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == (MSG_LEN_ADD - 8'd2) && in_data != SIDE_BUY && in_data != SIDE_SELL) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end else if (cnt_q == 8'd1) begin
            push_d  = 1'b1;
            state_d = S_LEN;
          end
        end
        S_SKIP: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_LEN;
        end
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_LEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LEN;
      len_q   <= '0;
      cnt_q   <= '0;
      body_q  <= '0;
      push_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      body_q  <= body_d;
      push_q  <= push_d;
      err_q   <= err_d;
      ovf_q   <= push_q && fifo_full && !pop;
    end
  end

  // body_q is stable during the push cycle because only S_ADD shifts it.
  assign rec.side     = (body_q[87:80] == SIDE_BUY);
  assign rec.order_id = body_q[79:48];
  assign rec.price    = body_q[47:16];
  assign rec.qty      = body_q[15:0];

  assign pop     = msg_valid && msg_ready;
  assign fifo_wr = push_q && (!fifo_full || pop);

  msg_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (rec),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign msg_valid    = !fifo_empty;
  assign msg_side     = head.side;
  assign msg_order_id = head.order_id;
  assign msg_price    = head.price;
  assign msg_qty      = head.qty;
  assign ovf_pulse    = ovf_q;
  assign err_pulse    = err_q;

`ifdef MSG_STATS_EN
  logic [CNT_W-1:0] msgs_q, errs_q, ovfs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msgs_q <= '0;
      errs_q <= '0;
      ovfs_q <= '0;
    end else begin
      if (fifo_wr && msgs_q != '1) msgs_q <= msgs_q + 1'b1;
      if (err_q && errs_q != '1)   errs_q <= errs_q + 1'b1;
      if (ovf_q && ovfs_q != '1)   ovfs_q <= ovfs_q + 1'b1;
    end
  end

  assign stat_msgs = msgs_q;
  assign stat_err  = errs_q;
  assign stat_ovf  = ovfs_q;
`endif

endmodule

// File: tb/tb_udp_msg_parser.sv
// Scoreboard bench for udp_msg_parser: expected records queued at stimulus time, compared on handshake.
module tb_udp_msg_parser;
  import udp_msg_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic        msg_side;
  logic [31:0] msg_order_id;
  logic [31:0] msg_price;
  logic [15:0] msg_qty;
  logic        ovf_pulse;
  logic        err_pulse;
`ifdef MSG_STATS_EN
  logic [15:0] stat_msgs, stat_err, stat_ovf;
`endif

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  int exp_pushes = 0;
  msg_rec_t exp_q[$];

  always #5 clk = ~clk;

  udp_msg_parser #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_side     (msg_side),
    .msg_order_id (msg_order_id),
    .msg_price    (msg_price),
    .msg_qty      (msg_qty),
    .ovf_pulse    (ovf_pulse),
    .err_pulse    (err_pulse)
`ifdef MSG_STATS_EN
    ,
    .stat_msgs    (stat_msgs),
    .stat_err     (stat_err),
    .stat_ovf     (stat_ovf)
`endif
  );

  // Output monitor: pops the scoreboard on every accepted record, tallies pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (err_pulse) err_seen++;
      if (ovf_pulse) ovf_seen++;
      if (msg_valid && msg_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_record: got id=%0d price=%0d qty=%0d side=%0d, expected none",
                   msg_order_id, msg_price, msg_qty, msg_side);
        end else begin
          msg_rec_t e;
          e = exp_q.pop_front();
          if ({msg_side, msg_order_id, msg_price, msg_qty} !== e) begin
            errors++;
            $display("FAIL record: got side=%0d id=%0d price=%0d qty=%0d, expected side=%0d id=%0d price=%0d qty=%0d",
                     msg_side, msg_order_id, msg_price, msg_qty, e.side, e.order_id, e.price, e.qty);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic bq_t make_add(input logic [7:0] side, input logic [31:0] id,
                                   input logic [31:0] price, input logic [15:0] qty);
    bq_t r;
    r = {8'h0D, 8'h41, side,
         id[31:24], id[23:16], id[15:8], id[7:0],
         price[31:24], price[23:16], price[15:8], price[7:0],
         qty[15:8], qty[7:0]};
    return r;
  endfunction

  function automatic msg_rec_t make_rec(input logic [7:0] side, input logic [31:0] id,
                                        input logic [31:0] price, input logic [15:0] qty);
    msg_rec_t r;
    r.side     = (side == 8'h42);
    r.order_id = id;
    r.price    = price;
    r.qty      = qty;
    return r;
  endfunction

  task automatic send_bytes(input bq_t b);
    foreach (b[i]) begin
      in_valid = 1'b1;
      in_data  = b[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic end_pkt();
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (msg_valid !== 1'b0 || err_pulse !== 1'b0 || ovf_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%0b err=%0b ovf=%0b, expected 0 0 0", msg_valid, err_pulse, ovf_pulse);
    end
    checks++;
    if ({msg_side, msg_order_id, msg_price, msg_qty} !== 81'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h, expected 0", {msg_side, msg_order_id, msg_price, msg_qty});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    msg_ready = 1'b1;
    exp_q.push_back(make_rec(8'h42, 32'd42, 32'd100000, 16'd100));
    exp_pushes++;
    send_bytes(make_add(8'h42, 32'd42, 32'd100000, 16'd100));
    in_valid = 1'b0;
    checks++;
    if (msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: msg_valid=%0b one edge after last byte, expected 0", msg_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: msg_valid=%0b two edges after last byte, expected 1", msg_valid);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t1_drain: %0d records outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_skip_other();
    int e0;
    bq_t p;
    e0 = err_seen;
    p = {8'h04, 8'h58, 8'hAA, 8'hBB};
    p = {p, make_add(8'h42, 32'd42, 32'd100000, 16'd100)};
    exp_q.push_back(make_rec(8'h42, 32'd42, 32'd100000, 16'd100));
    exp_pushes++;
    send_bytes(p);
    end_pkt();
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t2_record: %0d records outstanding, expected 0", exp_q.size());
    end
    checks++;
    if (err_seen - e0 != 0) begin
      errors++;
      $display("FAIL t2_err: %0d err pulses, expected 0", err_seen - e0);
    end
  endtask

  task automatic test_truncated();
    int e0;
    bq_t p, c;
    e0 = err_seen;
    p = make_add(8'h42, 32'd42, 32'd100000, 16'd100);
    for (int i = 0; i < 7; i++) c.push_back(p[i]);
    send_bytes(c);
    end_pkt();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_seen - e0 != 1) begin
      errors++;
      $display("FAIL t3_err: %0d err pulses, expected 1", err_seen - e0);
    end
    checks++;
    if (msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL t3_norecord: msg_valid=%0b, expected 0", msg_valid);
    end
    exp_q.push_back(make_rec(8'h42, 32'd42, 32'd100000, 16'd100));
    exp_pushes++;
    send_bytes(p);
    end_pkt();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t3_recover: %0d records outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_malformed();
    int e0;
    bq_t p1, p2;
    e0 = err_seen;
    p1 = {8'h01};
    p1 = {p1, make_add(8'h42, 32'd7, 32'd7, 16'd7)};
    p2 = {8'h0C, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00};
    p2 = {p2, make_add(8'h53, 32'd8, 32'd8, 16'd8)};
    send_bytes(p1);
    end_pkt();
    send_bytes(p2);
    end_pkt();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_seen - e0 != 2) begin
      errors++;
      $display("FAIL t4_err: %0d err pulses, expected 2", err_seen - e0);
    end
    exp_q.push_back(make_rec(8'h53, 32'd9, 32'hDEADBEEF, 16'hFFFF));
    exp_pushes++;
    send_bytes(make_add(8'h53, 32'd9, 32'hDEADBEEF, 16'hFFFF));
    end_pkt();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t4_recover: %0d records outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int o0;
    bq_t p;
    o0 = ovf_seen;
    msg_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      p = {p, make_add(8'h42, i, 32'd1000 + i, 16'(i * 10))};
      if (i <= 4) begin
        exp_q.push_back(make_rec(8'h42, i, 32'd1000 + i, 16'(i * 10)));
        exp_pushes++;
      end
    end
    send_bytes(p);
    end_pkt();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ovf_seen - o0 != 1) begin
      errors++;
      $display("FAIL t5_ovf: %0d ovf pulses, expected 1", ovf_seen - o0);
    end
    checks++;
    if (msg_valid !== 1'b1 || msg_order_id !== 32'd1) begin
      errors++;
      $display("FAIL t5_head: valid=%0b id=%0d, expected 1 1", msg_valid, msg_order_id);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (msg_order_id !== 32'd1 || msg_price !== 32'd1001 || msg_qty !== 16'd10) begin
      errors++;
      $display("FAIL t5_hold: id=%0d price=%0d qty=%0d, expected 1 1001 10", msg_order_id, msg_price, msg_qty);
    end
    msg_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_drain_rate: %0d outstanding valid=%0b after 4 cycles, expected 0 0", exp_q.size(), msg_valid);
    end
`ifdef MSG_STATS_EN
    checks++;
    if (stat_msgs !== 16'(exp_pushes) || stat_err !== 16'(err_seen) || stat_ovf !== 16'(ovf_seen)) begin
      errors++;
      $display("FAIL stats: msgs=%0d err=%0d ovf=%0d, expected %0d %0d %0d",
               stat_msgs, stat_err, stat_ovf, exp_pushes, err_seen, ovf_seen);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bq_t p, t;
    msg_ready = 1'b0;
    p = make_add(8'h42, 32'd21, 32'd1, 16'd1);
    p = {p, make_add(8'h53, 32'd22, 32'd2, 16'd2)};
    t = make_add(8'h42, 32'd23, 32'd3, 16'd3);
    for (int i = 0; i < 6; i++) p.push_back(t[i]);
    send_bytes(p);
    checks++;
    if (msg_valid !== 1'b1 || msg_order_id !== 32'd21) begin
      errors++;
      $display("FAIL t6_pre: valid=%0b id=%0d, expected 1 21", msg_valid, msg_order_id);
    end
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (msg_valid !== 1'b0 || {msg_side, msg_order_id, msg_price, msg_qty} !== 81'd0) begin
      errors++;
      $display("FAIL t6_async: valid=%0b id=%0d, expected 0 0", msg_valid, msg_order_id);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    msg_ready = 1'b1;
    exp_q.push_back(make_rec(8'h42, 32'd42, 32'd100000, 16'd100));
    send_bytes(make_add(8'h42, 32'd42, 32'd100000, 16'd100));
    end_pkt();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t6_recover: %0d records outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_skip_other();
    test_truncated();
    test_malformed();
    test_overflow();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
